// File: rtl/riscv_pkg.sv
// Shared types, encodings and the `REG_SIZE macro for the RV32 execute/control slice.
// Optional macro RISCV_SLT_EN adds the SLT ALU operation.
`ifndef RISCV_REG_SIZE_DEFINED
`define RISCV_REG_SIZE_DEFINED
`define REG_SIZE [XLEN-1:0]
`endif

package riscv_pkg;
    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [6:0] {
        OP_R = 7'b0110011,
        OP_I = 7'b0010011,
        OP_L = 7'b0000011,
        OP_S = 7'b0100011,
        OP_B = 7'b1100011,
        OP_J = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD = 3'b000,
        F3_SLT = 3'b010,
        F3_XOR = 3'b100,
        F3_OR  = 3'b110,
        F3_AND = 3'b111
    } funct3_e;

    typedef enum logic [6:0] {
        F7_BASE = 7'b0000000,
        F7_ALT  = 7'b0100000
    } funct7_e;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4
`ifdef RISCV_SLT_EN
        , SLT = 3'd5
`endif
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_4   = 2'd0,
        PC_BEQ = 2'd1,
        PC_J   = 2'd2
    } PC_sel_e;

    typedef enum logic {
        Read  = 1'b0,
        Write = 1'b1
    } DataMem_sel_e;

    typedef enum logic {
        from_ALU     = 1'b0,
        from_DataMem = 1'b1
    } MReg_sel_e;

    typedef struct packed {
        logic    ok;
        alu_op_e op;
    } alu_dec_t;

    // Shared funct3 map for register and immediate arithmetic.
    function automatic alu_dec_t f3_to_alu(input logic [2:0] f3);
        alu_dec_t d;
        d.ok = 1'b1;
        d.op = ADD;
        case (f3)
            F3_ADD:  d.op = ADD;
            F3_XOR:  d.op = XOR;
            F3_OR:   d.op = OR;
            F3_AND:  d.op = AND;
`ifdef RISCV_SLT_EN
            F3_SLT:  d.op = SLT;
`endif
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/riscv_alu_core.sv
// Operand-B mux, 32-bit ALU and zero detect; purely combinational, zero latency.
// No flow control; SLT exists only when RISCV_SLT_EN is defined.
module riscv_alu_core
    import riscv_pkg::*;
(
    input  logic [2:0]   alu_op,
    input  logic         is_R,
    input  logic `REG_SIZE Rs1,
    input  logic `REG_SIZE Rs2,
    input  logic `REG_SIZE imm32,
    output logic `REG_SIZE result,
    output logic         is_equal
);
    logic `REG_SIZE op_b;

    assign op_b = is_R ? Rs2 : imm32;

    always_comb begin
        result = Rs1 + op_b;
        case (alu_op)
            SUB:     result = Rs1 - op_b;
            AND:     result = Rs1 & op_b;
            OR:      result = Rs1 | op_b;
            XOR:     result = Rs1 ^ op_b;
`ifdef RISCV_SLT_EN
            SLT:     result = {{(XLEN-1){1'b0}}, ($signed(Rs1) < $signed(op_b))};
`endif
            default: result = Rs1 + op_b;
        endcase
    end

    assign is_equal = (result == '0);
endmodule

// File: rtl/riscv_exec_ctrl.sv
// Main control + ALU control + ALU for the single-cycle RV32 core; optional RISCV_SLT_EN.
// Datapath outputs combinational (zero latency); only the sticky illegal flag is registered.
// No flow control; illegal holds until a synchronous active-high rst.
module riscv_exec_ctrl
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic `REG_SIZE Rs1,
    input  logic `REG_SIZE Rs2,
    input  logic `REG_SIZE imm32,
    output logic [2:0]   ALU_Op,
    output logic `REG_SIZE ALU_Result,
    output logic         is_equal,
    output logic         RegWrite,
    output logic         DataMem_RW,
    output logic         MReg,
    output logic [1:0]   PC_sel,
    output logic         is_R,
    output logic         illegal
);
    alu_op_e  alu_op;
    alu_dec_t f3_dec;
    logic     dec_illegal;

    assign f3_dec = f3_to_alu(funct3);

    always_comb begin
        RegWrite    = 1'b0;
        DataMem_RW  = Read;
        MReg        = from_ALU;
        PC_sel      = PC_4;
        is_R        = 1'b0;
        alu_op      = ADD;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                RegWrite = 1'b1;
                is_R     = 1'b1;
                if (funct7 == F7_BASE && f3_dec.ok) begin
                    alu_op = f3_dec.op;
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_op = SUB;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_I: begin
                RegWrite = 1'b1;
                if (f3_dec.ok) alu_op = f3_dec.op;
                else           dec_illegal = 1'b1;
            end
            OP_L: begin
                RegWrite = 1'b1;
                MReg     = from_DataMem;
            end
            OP_S: DataMem_RW = Write;
            OP_B: begin
                is_R   = 1'b1;
                alu_op = SUB;
                // Only BEQ is implemented; other branch kinds fall through to PC+4.
                if (funct3 == 3'b000) PC_sel = PC_BEQ;
                else                  dec_illegal = 1'b1;
            end
            OP_J:    PC_sel = PC_J;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign ALU_Op = alu_op;

    always_ff @(posedge clk) begin
        if (rst)              illegal <= 1'b0;
        else if (dec_illegal) illegal <= 1'b1;
    end

    riscv_alu_core u_alu (
        .alu_op   (alu_op),
        .is_R     (is_R),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .imm32    (imm32),
        .result   (ALU_Result),
        .is_equal (is_equal)
    );
endmodule

// File: tb/tb_riscv_exec_ctrl.sv
// Directed plus randomized checks of riscv_exec_ctrl against a table-driven reference model.
module tb_riscv_exec_ctrl;
    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] Rs1, Rs2, imm32;
    logic [2:0]  ALU_Op;
    logic [31:0] ALU_Result;
    logic        is_equal, RegWrite, DataMem_RW, MReg, is_R, illegal;
    logic [1:0]  PC_sel;

    int total = 0;
    int bad   = 0;

    // Control table: {RegWrite, DataMem_RW, MReg, PC_sel[1:0], is_R}
    logic [5:0] ctrl_tab [logic [6:0]];
    int         f3_tab   [logic [2:0]];

    logic [5:0]  e_ctrl;
    int          e_op;
    logic [31:0] e_res;
    logic        e_ill;
    logic        model_ill;

    riscv_exec_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .Rs1(Rs1), .Rs2(Rs2), .imm32(imm32), .ALU_Op(ALU_Op), .ALU_Result(ALU_Result),
        .is_equal(is_equal), .RegWrite(RegWrite), .DataMem_RW(DataMem_RW), .MReg(MReg),
        .PC_sel(PC_sel), .is_R(is_R), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        logic [31:0] opb;
        e_ill = 1'b0;
        e_op  = 0;
        if (ctrl_tab.exists(op)) e_ctrl = ctrl_tab[op];
        else begin
            e_ctrl = 6'b000000;
            e_ill  = 1'b1;
        end
        if (op == 7'b0110011) begin
            if (f7 == 7'h00 && f3_tab.exists(f3)) e_op = f3_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'b000) e_op = 1;
            else e_ill = 1'b1;
        end else if (op == 7'b0010011) begin
            if (f3_tab.exists(f3)) e_op = f3_tab[f3];
            else e_ill = 1'b1;
        end else if (op == 7'b1100011) begin
            e_op = 1;
            if (f3 != 3'b000) begin
                e_ill = 1'b1;
                e_ctrl[2:1] = 2'd0;
            end
        end
        opb = e_ctrl[0] ? b : im;
        case (e_op)
            1:       e_res = a - opb;
            2:       e_res = a & opb;
            3:       e_res = a | opb;
            4:       e_res = a ^ opb;
            5:       e_res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            default: e_res = a + opb;
        endcase
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic r);
        opcode = op; funct3 = f3; funct7 = f7;
        Rs1 = a; Rs2 = b; imm32 = im; rst = r;
        #2;
        model(op, f3, f7, a, b, im);
        check("alu_op",     {29'd0, ALU_Op},     e_op);
        check("alu_result", ALU_Result,          e_res);
        check("is_equal",   {31'd0, is_equal},   {31'd0, e_res == 32'd0});
        check("regwrite",   {31'd0, RegWrite},   {31'd0, e_ctrl[5]});
        check("datamem_rw", {31'd0, DataMem_RW}, {31'd0, e_ctrl[4]});
        check("mreg",       {31'd0, MReg},       {31'd0, e_ctrl[3]});
        check("pc_sel",     {30'd0, PC_sel},     {30'd0, e_ctrl[2:1]});
        check("is_r",       {31'd0, is_R},       {31'd0, e_ctrl[0]});
        @(posedge clk);
        if (r) model_ill = 1'b0;
        else if (e_ill) model_ill = 1'b1;
        #1;
        check("illegal", {31'd0, illegal}, {31'd0, model_ill});
    endtask

    localparam logic [6:0] R_ = 7'b0110011, I_ = 7'b0010011, L_ = 7'b0000011,
                           S_ = 7'b0100011, B_ = 7'b1100011, J_ = 7'b1101111;

    initial begin
        logic [6:0] ops [6];
        logic [6:0] op, f7;
        logic [31:0] a, b;
        ctrl_tab[R_] = 6'b100001;
        ctrl_tab[I_] = 6'b100000;
        ctrl_tab[L_] = 6'b101000;
        ctrl_tab[S_] = 6'b010000;
        ctrl_tab[B_] = 6'b000011;
        ctrl_tab[J_] = 6'b000100;
        f3_tab[3'b000] = 0;
        f3_tab[3'b100] = 4;
        f3_tab[3'b110] = 3;
        f3_tab[3'b111] = 2;
`ifdef RISCV_SLT_EN
        f3_tab[3'b010] = 5;
`endif
        ops[0] = R_; ops[1] = I_; ops[2] = L_; ops[3] = S_; ops[4] = B_; ops[5] = J_;
        model_ill = 1'b0;
        rst = 1'b1;
        opcode = R_; funct3 = 3'b000; funct7 = 7'h00;
        Rs1 = '0; Rs2 = '0; imm32 = '0;
        @(posedge clk); #1;

        // Reset state, then the directed cases.
        step(R_, 3'b000, 7'h00, 32'd5, 32'd7, 32'd99, 1'b1);
        check("add_literal", ALU_Result, 32'd12);
        step(I_, 3'b110, 7'h00, 32'h0F0, 32'h123, 32'h00F, 1'b0);
        check("ori_literal", ALU_Result, 32'h0FF);
        step(S_, 3'b010, 7'h00, 32'h100, 32'h55, 32'd8, 1'b0);
        check("sw_literal", ALU_Result, 32'h108);
        step(L_, 3'b010, 7'h00, 32'h200, 32'h0, 32'd4, 1'b0);
        step(B_, 3'b000, 7'h00, 32'd3, 32'd3, 32'd16, 1'b0);
        check("beq_eq", {31'd0, is_equal}, 32'd1);
        step(B_, 3'b000, 7'h00, 32'd3, 32'd4, 32'd16, 1'b0);
        check("beq_ne", ALU_Result, 32'hFFFFFFFF);
        step(R_, 3'b000, 7'h20, 32'd0, 32'd1, 32'd0, 1'b0);
        check("sub_wrap", ALU_Result, 32'hFFFFFFFF);
        step(J_, 3'b000, 7'h00, 32'd0, 32'd0, 32'd64, 1'b0);
        step(B_, 3'b001, 7'h00, 32'd1, 32'd1, 32'd0, 1'b0);
        step(R_, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 1'b1);
        step(7'h7F, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 1'b0);
        check("illegal_set", {31'd0, illegal}, 32'd1);
        step(R_, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 1'b0);
        check("illegal_held", {31'd0, illegal}, 32'd1);
        step(R_, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 1'b1);
        check("illegal_rst", {31'd0, illegal}, 32'd0);
        step(7'h7F, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 1'b1);
        check("illegal_rst_wins", {31'd0, illegal}, 32'd0);
        step(R_, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
`ifdef RISCV_SLT_EN
        check("slt_neg", ALU_Result, 32'd1);
`else
        check("f3_010_illegal", {31'd0, illegal}, 32'd1);
        check("f3_010_add", {29'd0, ALU_Op}, 32'd0);
`endif
        step(R_, 3'b000, 7'h00, 32'd0, 32'd0, 32'd0, 1'b1);

        // Randomized mix of legal and malformed encodings.
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step(op, 3'($urandom), f7, a, b, $urandom, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
